// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - staggered per-channel reset release with programmable clock-enable dividers
// Optional feature: define CLK_RST_ASSERT_STAGGER_EN for reverse-order staggered assertion on sw_rst_req.
module clk_rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int RST_CYCLES  = 5,
    parameter int STAGGER     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_rst_req,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    output logic [NUM_CH-1:0]       ch_rst_n,
    output logic [NUM_CH-1:0]       clk_en_o,
    output logic                    seq_done
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int STG_W  = $clog2(STAGGER + 1);
    localparam int IDX_W  = $clog2(NUM_CH + 1);

`ifdef CLK_RST_ASSERT_STAGGER_EN
    typedef enum logic [1:0] {HOLD, RELEASE, RUN, ASSERT} state_t;
`else
    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
`endif

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STG_W-1:0]   stg_cnt;
    logic [IDX_W-1:0]   idx;
    logic [SYNC_STAGES-1:0] sync;
    logic               rst_s;

    // Assertion is immediate; deassertion ripples through the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '1;
        else     sync <= {sync[SYNC_STAGES-2:0], 1'b0};
    end
    assign rst_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst || rst_s) begin
            state    <= HOLD;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            idx      <= '0;
            ch_rst_n <= '0;
            seq_done <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (int'(hold_cnt) >= RST_CYCLES - 1) begin
                        state       <= RELEASE;
                        ch_rst_n[0] <= 1'b1;
                        idx         <= IDX_W'(1);
                        stg_cnt     <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                // idx is the next channel to release
                RELEASE: begin
                    if (int'(idx) >= NUM_CH) begin
                        state    <= RUN;
                        seq_done <= 1'b1;
                    end else if (int'(stg_cnt) >= STAGGER - 1) begin
                        for (int i = 0; i < NUM_CH; i++)
                            if (i == int'(idx)) ch_rst_n[i] <= 1'b1;
                        idx     <= idx + 1'b1;
                        stg_cnt <= '0;
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        seq_done <= 1'b0;
                        hold_cnt <= '0;
                        stg_cnt  <= '0;
`ifdef CLK_RST_ASSERT_STAGGER_EN
                        state              <= ASSERT;
                        ch_rst_n[NUM_CH-1] <= 1'b0;
                        idx                <= IDX_W'(NUM_CH - 1);
`else
                        state    <= HOLD;
                        ch_rst_n <= '0;
                        idx      <= '0;
`endif
                    end
                end
`ifdef CLK_RST_ASSERT_STAGGER_EN
                // idx counts channels still released; channel idx-1 falls next
                ASSERT: begin
                    if (idx == '0) begin
                        state <= HOLD;
                    end else if (int'(stg_cnt) >= STAGGER - 1) begin
                        for (int i = 0; i < NUM_CH; i++)
                            if (i == int'(idx) - 1) ch_rst_n[i] <= 1'b0;
                        idx     <= idx - 1'b1;
                        stg_cnt <= '0;
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
`endif
                default: state <= HOLD;
            endcase
        end
    end

    logic [CNT_W-1:0] cnt   [NUM_CH];
    logic [CNT_W-1:0] r_lat [NUM_CH];
    logic [CNT_W-1:0] r_eff [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            r_eff[i] = div_ratio[i*CNT_W +: CNT_W];
            if (r_eff[i] == '0) r_eff[i] = CNT_W'(1);
        end
    end

    // Ratio is captured only at the wrap so a period is never cut short or stretched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= '0;
                r_lat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_rst_n[i]) begin
                    cnt[i]   <= '0;
                    r_lat[i] <= '0;
                end else if (cnt[i] == '0) begin
                    r_lat[i] <= r_eff[i];
                    cnt[i]   <= (r_eff[i] == CNT_W'(1)) ? '0 : CNT_W'(1);
                end else begin
                    cnt[i] <= (cnt[i] == r_lat[i] - CNT_W'(1)) ? '0 : cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            clk_en_o[i] = ch_rst_n[i] && (cnt[i] == '0);
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - directed checks of clk_rst_seq release timing, dividers and re-sequencing
module tb_clk_rst_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw_rst_req = 1'b0;
    logic [31:0] div_ratio;
    logic [3:0]  ch_rst_n;
    logic [3:0]  clk_en_o;
    logic        seq_done;

    int vectors = 0;
    int miscompares = 0;
    int rel [4];
    int rat [4];

    always #5 clk = ~clk;

    clk_rst_seq dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .div_ratio  (div_ratio),
        .ch_rst_n   (ch_rst_n),
        .clk_en_o   (clk_en_o),
        .seq_done   (seq_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_en(input int i, input int t);
        if (t < rel[i]) return 1'b0;
        return ((t - rel[i]) % rat[i]) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge right after rst falls; edge n is the n-th posedge after that.
    task automatic run_seq(input int n_max);
        logic [3:0] er, ee;
        for (int k = 0; k < 4; k++) rel[k] = 7 + 2*k;
        for (int n = 1; n <= n_max; n++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                er[k] = (n >= rel[k]);
                ee[k] = exp_en(k, n);
            end
            check("seq_rst_n", 32'(ch_rst_n), 32'(er));
            check("seq_done",  32'(seq_done), 32'(n >= 14));
            check("seq_en",    32'(clk_en_o), 32'(ee));
        end
    endtask

    initial begin
        logic [3:0] er, ee, mask;
        int base;

        div_ratio = {8'd5, 8'd3, 8'd1, 8'd0};
        rat[0] = 1; rat[1] = 1; rat[2] = 3; rat[3] = 5;
        repeat (10) @(negedge clk);
        check("rst_rst_n", 32'(ch_rst_n), 32'h0);
        check("rst_en",    32'(clk_en_o), 32'h0);
        check("rst_done",  32'(seq_done), 32'h0);
        rst = 1'b0;
        run_seq(44);

        // ch2 ratio 3->4 while its counter sits at 1
        for (int n = 45; n <= 60; n++) begin
            step();
            if (n == 47) begin
                rel[2] = 47;
                rat[2] = 4;
            end
            for (int k = 0; k < 4; k++) ee[k] = exp_en(k, n);
            check("ratio_en", 32'(clk_en_o), 32'(ee));
            if (n == 45) div_ratio[23:16] = 8'd4;
        end

`ifdef CLK_RST_ASSERT_STAGGER_EN
        base = 7;
`else
        base = 0;
`endif
        for (int k = 0; k < 4; k++) rel[k] = base + 5 + 2*k;
        sw_rst_req = 1'b1;
        for (int m = 0; m <= 25; m++) begin
            step();
            sw_rst_req = 1'b0;
            for (int k = 0; k < 4; k++) begin
`ifdef CLK_RST_ASSERT_STAGGER_EN
                mask[k] = !(m < 2*(3 - k));
`else
                mask[k] = 1'b1;
`endif
                er[k] = (m >= rel[k]) || !mask[k];
                ee[k] = exp_en(k, m);
            end
            check("sw_rst_n", 32'(ch_rst_n), 32'(er));
            check("sw_done",  32'(seq_done), 32'(m >= base + 12));
            check("sw_en",    32'(clk_en_o & mask), 32'(ee & mask));
            // pulses during HOLD/ASSERT and RELEASE must be ignored
            if (m == 1 || m == base + 5) sw_rst_req = 1'b1;
        end

        rst = 1'b1;
        step();
        step();
        check("rst2_done", 32'(seq_done), 32'h0);
        rst = 1'b0;
        run_seq(9);
        check("pre_async_rst_n", 32'(ch_rst_n), 32'h3);
        check("pre_async_en",    32'(clk_en_o), 32'h3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_n", 32'(ch_rst_n), 32'h0);
        check("async_en",    32'(clk_en_o), 32'h0);
        check("async_done",  32'(seq_done), 32'h0);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        run_seq(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
